l2_return_router: RTL
=====================

L2_RETURN_ROUTER -- requirements
Module: l2_return_router

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesting ports, 1..8.
REQ-002 SHALL have parameter SUB_ID_W, default 2: per-port sub-ID width.
REQ-003 SHALL have parameter ATTR_FIFO_DEPTH, default 8: burst attribute queue depth, power of 2.
REQ-004 SHALL have parameter RETURN_FIFO_DEPTH, default 2: per-port return buffer depth, power of 2, >=1.
REQ-005 SHALL have ports clk (in, 1, sole clock, rising edge) and rst (in, 1, synchronous active-high reset).
REQ-006 SHALL have attr_push (in, 1, enqueue burst attribute), attr_id (in, PORT_W = max(1, clog2(NUM_PORTS)), destination port), attr_burst_size (in, 5, beats minus one) and attr_abort (in, 1, discard burst data).
REQ-007 SHALL have attr_full (out, 1): attribute queue full.
REQ-008 SHALL have mem_rd_data_valid (in, 1), mem_rd_data (in, 32) and mem_rd_sub_id (in, SUB_ID_W): memory return beat.
REQ-009 SHALL have mem_rd_data_ack (out, 1): beat consumed this cycle.
REQ-010 SHALL have port_rd_data_valid (out, NUM_PORTS), port_rd_data (out, NUM_PORTS*32) and port_rd_sub_id (out, NUM_PORTS*SUB_ID_W): per-port return, port p in slice p.
REQ-011 SHALL have port_rd_data_ack (in, NUM_PORTS): per-port pop.
REQ-012 SHALL have burst_done (out, 1): one-cycle pulse on the final beat of a burst.

Function
REQ-013 Attribute queue: FIFO of {id, burst_size, abort}; push when attr_push && !attr_full; push while full SHALL be ignored with no state change.
REQ-014 Head attribute defines current burst: beats = burst_size+1 (0 -> 1 beat, 31 -> 32 beats).
REQ-015 mem_rd_data_ack = mem_rd_data_valid && attr queue non-empty && (head.abort || return FIFO[head.id] not full).
REQ-016 mem_rd_data_ack SHALL NOT depend combinationally on port_rd_data_ack (full FIFO popped this cycle still blocks).
REQ-017 Accepted non-aborted beat SHALL push {mem_rd_sub_id, mem_rd_data} into return FIFO[head.id]; aborted beats SHALL be consumed and dropped.
REQ-018 5-bit beat counter SHALL increment per accepted beat; on beat == burst_size: counter -> 0, head popped, burst_done = 1 same cycle.
REQ-019 Attribute push and pop in same cycle SHALL be allowed, including when full (pop frees slot only next cycle; push while full still ignored) and when empty (push only).
REQ-020 Latency: beat accepted in cycle N SHALL be visible on port_rd_data_valid/data in cycle N+1.
REQ-021 port_rd_data_valid[p] = return FIFO[p] non-empty; port_rd_data_ack[p] while empty SHALL be ignored.
REQ-022 Return FIFO push and pop in same cycle SHALL be allowed; occupancy unchanged.
REQ-023 FIFO pointers SHALL wrap modulo depth; occupancy counters SHALL be clog2(depth)+1 bits.
REQ-024 attr_id >= NUM_PORTS SHALL be treated as abort (data dropped, burst counted).
REQ-025 Beats for different ports SHALL be delivered strictly in attribute order; no reordering.

Reset
REQ-026 On rst: all FIFOs empty, beat counter 0, attr_full 0, mem_rd_data_ack 0, port_rd_data_valid 0, burst_done 0.
REQ-027 rst mid-burst SHALL discard the partial burst and all queued attributes and data; the first cycle after reset starts from empty.

Structure
REQ-028 Shared package l2_config_and_types SHALL gain l2_burst_attr_t {id, burst_size, abort} and l2_port_return_t {sub_id, data}, parametrised by L2_NUM_PORTS/L2_SUB_ID_W.
REQ-029 One sub-module l2_sync_fifo (parametrised width/depth, full/empty, registered output) SHALL be used for the attribute queue and each return FIFO.

Verification
REQ-030 Attr {id=1, size=3, abort=0}, 4 beats 0xA0..0xA3 sub_id=2 -> port 1 receives 4 beats in order, each 1 cycle after its ack; burst_done on 4th; port 0 is idle.
REQ-031 Attr {id=0, size=1, abort=1}, 2 beats -> both acked, no port valid, burst_done on 2nd.
REQ-032 RETURN_FIFO_DEPTH=2, port 0 ack held 0, 4-beat burst -> ack only on beats 1-2; beat 3 accepted one cycle after the first port ack.
REQ-033 Push 8 attrs (DEPTH=8) -> attr_full=1; 9th push ignored; after one size-0 burst completes, attr_full=0 next cycle.
REQ-034 Mem valid with empty attribute queue -> mem_rd_data_ack stays 0.
REQ-035 rst asserted after beat 2 of a size-3 burst -> all outputs 0 next cycle; new size-0 burst then routes correctly.

Source files
------------

// File: rtl/l2_return_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module : l2_config_and_types (package)
//  Brief  : Shared L2 configuration constants and the burst-attribute /
//           port-return record types used by the return router.
//           The record types are sized for the default L2 configuration
//           (L2_NUM_PORTS / L2_SUB_ID_W). Blocks built with other port
//           counts derive matching widths through l2_port_w().
//  Rev    : 1.0 - initial release
// ============================================================================
package l2_config_and_types;

    localparam int L2_NUM_PORTS = 2;
    localparam int L2_SUB_ID_W  = 2;
    localparam int L2_DATA_W    = 32;
    localparam int L2_BURST_W   = 5;

    // Port-select width. It is never narrower than one bit, so a
    // single-port build still has a usable id field.
    function automatic int l2_port_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    localparam int L2_PORT_W = l2_port_w(L2_NUM_PORTS);

    typedef struct packed {
        logic [L2_PORT_W-1:0]  id;
        logic [L2_BURST_W-1:0] burst_size;
        logic                  abort;
    } l2_burst_attr_t;

    typedef struct packed {
        logic [L2_SUB_ID_W-1:0] sub_id;
        logic [L2_DATA_W-1:0]   data;
    } l2_port_return_t;

endpackage
`default_nettype wire

// File: rtl/l2_return_router_fifo.sv
`default_nettype none
// ============================================================================
//  Module : l2_sync_fifo
//  Brief  : Single-clock FIFO with full/empty flags. The head entry is held
//           in the storage registers, so a write in cycle N is visible at
//           pop_data in cycle N+1. A push while full and a pop while empty
//           are ignored. Push and pop in the same cycle keep the occupancy.
//  Ports  : clk, rst        - clock, synchronous active-high reset
//           push, push_data - write request and data
//           pop             - remove head entry
//           pop_data        - current head entry
//           full, empty     - occupancy flags
//  Rev    : 1.0 - initial release
// ============================================================================
module l2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Explicit wrap keeps the pointer legal for any depth, including 1.
    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] ptr);
        if (ptr == c_ptr_w'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + c_ptr_w'(1);
    endfunction

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_return_router.sv
`default_nettype none
// ============================================================================
//  Module : l2_return_router
//  Brief  : Routes memory read-return beats to per-port return FIFOs. A queue
//           of burst attributes (destination port, beat count, abort) holds
//           one entry per outstanding burst. Its head decides where each
//           accepted beat goes. The head retires on the last beat of its burst.
//  Ports  : clk, rst                        - clock, sync active-high reset
//           attr_push/attr_id/attr_burst_size/attr_abort - burst attribute in
//           attr_full                       - attribute queue full
//           mem_rd_data_valid/data/sub_id   - memory return beat
//           mem_rd_data_ack                 - beat consumed this cycle
//           port_rd_data_valid/data/sub_id  - per-port return, port p in slice p
//           port_rd_data_ack                - per-port pop
//           burst_done                      - pulse on the final beat of a burst
//  Rev    : 1.0 - initial release
// ============================================================================
module l2_return_router
    import l2_config_and_types::*;
#(
    parameter int NUM_PORTS         = L2_NUM_PORTS,
    parameter int SUB_ID_W          = L2_SUB_ID_W,
    parameter int ATTR_FIFO_DEPTH   = 8,
    parameter int RETURN_FIFO_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                attr_push,
    input  logic [l2_port_w(NUM_PORTS)-1:0]     attr_id,
    input  logic [L2_BURST_W-1:0]               attr_burst_size,
    input  logic                                attr_abort,
    output logic                                attr_full,
    input  logic                                mem_rd_data_valid,
    input  logic [L2_DATA_W-1:0]                mem_rd_data,
    input  logic [SUB_ID_W-1:0]                 mem_rd_sub_id,
    output logic                                mem_rd_data_ack,
    output logic [NUM_PORTS-1:0]                port_rd_data_valid,
    output logic [NUM_PORTS*L2_DATA_W-1:0]      port_rd_data,
    output logic [NUM_PORTS*SUB_ID_W-1:0]       port_rd_sub_id,
    input  logic [NUM_PORTS-1:0]                port_rd_data_ack,
    output logic                                burst_done
);

    localparam int c_port_w = l2_port_w(NUM_PORTS);
    localparam int c_ret_w  = SUB_ID_W + L2_DATA_W;

    // Same layout as l2_burst_attr_t, sized for this instance's port count.
    typedef struct packed {
        logic [c_port_w-1:0]   id;
        logic [L2_BURST_W-1:0] burst_size;
        logic                  abort;
    } burst_attr_t;

    burst_attr_t           w_attr_in;
    burst_attr_t           w_head;
    logic                  w_attr_empty;
    logic                  w_head_drop;
    logic                  w_head_port_full;
    logic                  w_ack;
    logic                  w_last_beat;
    logic [L2_BURST_W-1:0] r_beat_cnt;
    logic [NUM_PORTS-1:0]  w_ret_full;
    logic [NUM_PORTS-1:0]  w_ret_empty;
    logic [c_ret_w-1:0]    w_ret_in;

    assign w_attr_in = '{id: attr_id, burst_size: attr_burst_size, abort: attr_abort};

    l2_sync_fifo #(
        .WIDTH ($bits(burst_attr_t)),
        .DEPTH (ATTR_FIFO_DEPTH)
    ) u_attr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (attr_push),
        .push_data (w_attr_in),
        .pop       (burst_done),
        .pop_data  (w_head),
        .full      (attr_full),
        .empty     (w_attr_empty)
    );

    // A head aimed at a non-existent port behaves like an aborted burst.
    // Its beats are consumed and counted but never stored.
    always_comb begin
        w_head_drop      = w_head.abort || (int'(w_head.id) >= NUM_PORTS);
        w_head_port_full = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(w_head.id) == p) begin
                w_head_port_full = w_ret_full[p];
            end
        end
    end

    // Backpressure uses the registered full flag only. A FIFO popped in this
    // same cycle still blocks, which keeps port acks out of this path.
    assign w_ack = mem_rd_data_valid && !w_attr_empty && !rst &&
                   (w_head_drop || !w_head_port_full);
    assign w_last_beat     = (r_beat_cnt == w_head.burst_size);
    assign mem_rd_data_ack = w_ack;
    assign burst_done      = w_ack && w_last_beat;
    assign w_ret_in        = {mem_rd_sub_id, mem_rd_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_ack) begin
            r_beat_cnt <= w_last_beat ? '0 : (r_beat_cnt + L2_BURST_W'(1));
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic               w_push;
        logic [c_ret_w-1:0] w_ret_out;

        assign w_push = w_ack && !w_head_drop && (int'(w_head.id) == p);

        l2_sync_fifo #(
            .WIDTH (c_ret_w),
            .DEPTH (RETURN_FIFO_DEPTH)
        ) u_ret_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (w_push),
            .push_data (w_ret_in),
            .pop       (port_rd_data_ack[p]),
            .pop_data  (w_ret_out),
            .full      (w_ret_full[p]),
            .empty     (w_ret_empty[p])
        );

        assign port_rd_data_valid[p]                    = !w_ret_empty[p];
        assign port_rd_data[p*L2_DATA_W +: L2_DATA_W]   = w_ret_out[L2_DATA_W-1:0];
        assign port_rd_sub_id[p*SUB_ID_W +: SUB_ID_W]   = w_ret_out[c_ret_w-1 -: SUB_ID_W];
    end

endmodule
`default_nettype wire
